// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - bus bundle between the register file and its user
//
// Groups the write port, both read ports, the debug port and the write counter.
//   master : drives regWrite/readReg1/readReg2/writeReg/writeData/dbgReg,
//            observes readData1/readData2/dbgData/writeCount
//   slave  : the register file side (mirror of master)

interface register_file_if #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 5
);
    logic                  regWrite;
    logic [DEPTH_LOG2-1:0] readReg1;
    logic [DEPTH_LOG2-1:0] readReg2;
    logic [DEPTH_LOG2-1:0] writeReg;
    logic [WIDTH-1:0]      writeData;
    logic [DEPTH_LOG2-1:0] dbgReg;
    logic [WIDTH-1:0]      readData1;
    logic [WIDTH-1:0]      readData2;
    logic [WIDTH-1:0]      dbgData;
    logic [31:0]           writeCount;

    modport master (
        output regWrite, readReg1, readReg2, writeReg, writeData, dbgReg,
        input  readData1, readData2, dbgData, writeCount
    );

    modport slave (
        input  regWrite, readReg1, readReg2, writeReg, writeData, dbgReg,
        output readData1, readData2, dbgData, writeCount
    );
endinterface

// File: rtl/register_file.sv
// rtl/register_file.sv - 32 x 32-bit MIPS general-purpose register file
//
// Two combinational read ports (optionally bypassing the in-flight write),
// one synchronous write port, a never-bypassed debug read port and a
// committed-write counter. Register 0 is hardwired to zero.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears all registers and the counter
//   rf    : register_file_if slave port (see register_file_if.sv)

module register_file #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 5,
    parameter bit BYPASS     = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    register_file_if.slave rf
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [31:0]      write_count_q;
    logic [31:0]      write_count_d;
    logic             wr_en;
    logic             hit1;
    logic             hit2;

    // Writes to r0 are dropped here so r0 storage stays zero after reset and
    // the counter only sees writes that actually land.
    always_comb begin
        wr_en         = rf.regWrite && (rf.writeReg != '0);
        regs_d        = regs_q;
        write_count_d = write_count_q;
        if (wr_en) begin
            regs_d[rf.writeReg] = rf.writeData;
            write_count_d       = write_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            write_count_q <= '0;
        end else begin
            regs_q        <= regs_d;
            write_count_q <= write_count_d;
        end
    end

    // Bypass is gated by rst_n so that a write presented while in reset can
    // never leak onto the read ports.
    always_comb begin
        hit1 = BYPASS && rst_n && wr_en && (rf.readReg1 == rf.writeReg);
        hit2 = BYPASS && rst_n && wr_en && (rf.readReg2 == rf.writeReg);

        if (!rst_n || (rf.readReg1 == '0)) begin
            rf.readData1 = '0;
        end else if (hit1) begin
            rf.readData1 = rf.writeData;
        end else begin
            rf.readData1 = regs_q[rf.readReg1];
        end

        if (!rst_n || (rf.readReg2 == '0)) begin
            rf.readData2 = '0;
        end else if (hit2) begin
            rf.readData2 = rf.writeData;
        end else begin
            rf.readData2 = regs_q[rf.readReg2];
        end

        if (!rst_n || (rf.dbgReg == '0)) begin
            rf.dbgData = '0;
        end else begin
            rf.dbgData = regs_q[rf.dbgReg];
        end

        rf.writeCount = rst_n ? write_count_q : 32'd0;
    end
endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed bench for register_file, bypass on and off

module tb_register_file;
    logic        clk;
    logic        rst_n;
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  dr;

    int total = 0;
    int bad   = 0;

    register_file_if #(.WIDTH(32), .DEPTH_LOG2(5)) if_b ();
    register_file_if #(.WIDTH(32), .DEPTH_LOG2(5)) if_n ();

    assign if_b.regWrite  = we;
    assign if_b.writeReg  = wr;
    assign if_b.writeData = wd;
    assign if_b.readReg1  = r1;
    assign if_b.readReg2  = r2;
    assign if_b.dbgReg    = dr;
    assign if_n.regWrite  = we;
    assign if_n.writeReg  = wr;
    assign if_n.writeData = wd;
    assign if_n.readReg1  = r1;
    assign if_n.readReg2  = r2;
    assign if_n.dbgReg    = dr;

    register_file #(.WIDTH(32), .DEPTH_LOG2(5), .BYPASS(1'b1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (if_b.slave)
    );

    register_file #(.WIDTH(32), .DEPTH_LOG2(5), .BYPASS(1'b0)) dut_n (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (if_n.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  dr;
        logic [31:0] e1;    // readData1, bypass on, before the edge
        logic [31:0] e2;    // readData2, bypass on, before the edge
        logic [31:0] ed;    // dbgData, before the edge
        logic [31:0] ecnt;  // writeCount, before the edge
        logic [31:0] n1;    // readData1, bypass off, before the edge
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ALU model downstream of the register file: 010 = add.
    function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        //          we    wr     wd            r1     r2     dr     e1            e2            ed            cnt    n1
        vecs[0] = '{1'b1, 5'd8,  32'hDEADBEEF, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'd0, 32'h0};
        vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd8,  5'd8,  5'd8,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'd1, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd8,  5'd0,  32'h0,        32'hDEADBEEF, 32'h0,        32'd1, 32'h0};
        vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'd1, 32'h0};
        vecs[4] = '{1'b1, 5'd3,  32'h11,       5'd3,  5'd4,  5'd3,  32'h11,       32'h0,        32'h0,        32'd1, 32'h0};
        vecs[5] = '{1'b1, 5'd3,  32'h22,       5'd3,  5'd3,  5'd3,  32'h22,       32'h22,       32'h11,       32'd2, 32'h11};
        vecs[6] = '{1'b0, 5'd9,  32'hAAAA,     5'd3,  5'd9,  5'd3,  32'h22,       32'h0,        32'h22,       32'd3, 32'h22};
        vecs[7] = '{1'b0, 5'd0,  32'h0,        5'd9,  5'd9,  5'd9,  32'h0,        32'h0,        32'h0,        32'd3, 32'h0};

        rst_n = 1'b0;
        we = 1'b0; wr = '0; wd = '0; r1 = 5'd5; r2 = 5'd8; dr = 5'd3;
        #2;
        check("reset_rd1", if_b.readData1, 32'h0);
        check("reset_rd2", if_b.readData2, 32'h0);
        check("reset_dbg", if_b.dbgData, 32'h0);
        check("reset_cnt", if_b.writeCount, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            we = vecs[i].we; wr = vecs[i].wr; wd = vecs[i].wd;
            r1 = vecs[i].r1; r2 = vecs[i].r2; dr = vecs[i].dr;
            #1;
            check($sformatf("vec%0d_b_rd1", i), if_b.readData1, vecs[i].e1);
            check($sformatf("vec%0d_b_rd2", i), if_b.readData2, vecs[i].e2);
            check($sformatf("vec%0d_b_dbg", i), if_b.dbgData, vecs[i].ed);
            check($sformatf("vec%0d_b_cnt", i), if_b.writeCount, vecs[i].ecnt);
            check($sformatf("vec%0d_n_rd1", i), if_n.readData1, vecs[i].n1);
            check($sformatf("vec%0d_n_dbg", i), if_n.dbgData, vecs[i].ed);
            check($sformatf("vec%0d_n_cnt", i), if_n.writeCount, vecs[i].ecnt);
        end

        // Asynchronous reset between edges after a write to r5.
        @(negedge clk);
        we = 1'b1; wr = 5'd5; wd = 32'h12345678; r1 = 5'd5; dr = 5'd5;
        @(posedge clk);
        #1;
        we = 1'b0;
        #1;
        check("pre_rst_rd1", if_b.readData1, 32'h12345678);
        check("pre_rst_cnt", if_b.writeCount, 32'd4);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_rd1", if_b.readData1, 32'h0);
        check("async_rst_n_rd1", if_n.readData1, 32'h0);
        check("async_rst_dbg", if_b.dbgData, 32'h0);
        check("async_rst_cnt", if_b.writeCount, 32'h0);

        // Write presented and clocked while in reset is ignored.
        we = 1'b1; wr = 5'd7; wd = 32'h77; r1 = 5'd7; dr = 5'd7;
        #1;
        check("rst_bypass_rd1", if_b.readData1, 32'h0);
        @(posedge clk);
        #1;
        check("rst_write_rd1", if_b.readData1, 32'h0);
        check("rst_write_cnt", if_b.writeCount, 32'h0);
        @(negedge clk);
        we = 1'b0;
        rst_n = 1'b1;
        #1;
        check("post_rst_r7", if_b.dbgData, 32'h0);
        check("post_rst_cnt", if_b.writeCount, 32'h0);

        // Short reset pulse with no clock edge inside it.
        @(negedge clk);
        we = 1'b1; wr = 5'd6; wd = 32'h66; r1 = 5'd6; dr = 5'd6;
        @(posedge clk);
        #1;
        we = 1'b0;
        #1;
        check("pulse_pre_r6", if_b.dbgData, 32'h66);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
        check("pulse_r6", if_b.dbgData, 32'h0);
        check("pulse_rd1", if_n.readData1, 32'h0);
        check("pulse_cnt", if_b.writeCount, 32'h0);

        // Full sweep: r1..r31 = 0x100+i, then pairs into the ALU.
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            we = 1'b1; wr = 5'(i); wd = 32'h100 + 32'(i);
        end
        @(negedge clk);
        we = 1'b0;
        #1;
        check("sweep_cnt_b", if_b.writeCount, 32'd31);
        check("sweep_cnt_n", if_n.writeCount, 32'd31);
        for (int i = 1; i < 32; i++) begin
            r1 = 5'(i); r2 = 5'(32 - i); dr = 5'(i);
            #1;
            check($sformatf("alu_b_%0d", i), alu(3'b010, if_b.readData1, if_b.readData2), 32'h220);
            check($sformatf("alu_n_%0d", i), alu(3'b010, if_n.readData1, if_n.readData2), 32'h220);
            check($sformatf("dbg_%0d", i), if_b.dbgData, 32'h100 + 32'(i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32 x 32-bit MIPS general-purpose register file, directly upstream of the ALU.
- readData1 drives ALU operand a. readData2 drives ALU operand b, through the ALUSrc mux outside this block.
- Write-back (ALU result or memory load data) is committed on the rising clock edge.
- Two combinational read ports, one synchronous write port, a debug read port and a write counter for the bench.

Parameters:
- WIDTH, 32, data width of each register.
- DEPTH_LOG2, 5, address width; the file holds 2**DEPTH_LOG2 registers.
- BYPASS, 1, when 1 a read of the address being written in the same cycle returns writeData; when 0 it returns the stored (old) value.

Ports:
- clk  input  1  system clock, rising edge active.
- rst_n  input  1  reset, asynchronous, active-low.
- regWrite  input  1  write enable for the write port.
- readReg1  input  DEPTH_LOG2  rs address.
- readReg2  input  DEPTH_LOG2  rt address.
- writeReg  input  DEPTH_LOG2  destination address (rd/rt, chosen by the RegDst mux outside this block).
- writeData  input  WIDTH  write-back value.
- dbgReg  input  DEPTH_LOG2  debug read address.
- readData1  output  WIDTH  contents of readReg1.
- readData2  output  WIDTH  contents of readReg2.
- dbgData  output  WIDTH  contents of dbgReg (never bypassed).
- writeCount  output  32  number of committed writes since reset.

Behaviour:
- Reset (rst_n low) clears, asynchronously and immediately, every register and writeCount to 0. It is held cleared while rst_n is low.
- While rst_n is low, every read output returns 0 and any write is ignored.
- Release of rst_n is synchronised to clk by the system. The first write is possible on the first rising edge with rst_n high.
- Write: on a rising clk edge with rst_n high, regWrite=1 and writeReg!=0, register[writeReg] <= writeData and writeCount increments by 1.
- writeCount wraps from 0xFFFFFFFF to 0.
- Register 0 is hardwired to 0. A write with writeReg==0 is discarded, does not increment writeCount, and all reads of address 0 return 0.
- Reads are purely combinational: zero-cycle latency from the address inputs and stored state.
- A value written at edge N is visible on the read ports immediately after edge N.
- Read-during-write with BYPASS=1: if regWrite=1, writeReg!=0 and readRegX==writeReg, readDataX = writeData in the same cycle, before the edge. This is needed where write-back and decode overlap.
- Read-during-write with BYPASS=0: the ports return the stored value until the edge.
- Both read ports may address the same register, including the register being written; each port resolves independently.
- dbgData always returns the stored value, with no bypass; it returns 0 for address 0.
- If regWrite is X or Z, the design treats it as a don't-care; the bench never drives it so.
- Reset asserted mid-operation:
  - If rst_n falls in the same cycle as a pending write, the write is lost and all registers read 0.
  - If rst_n falls and rises again with no clock edge in between, all registers still read 0 afterwards.
- No other state. No stall, handshake or busy signal: the write port always accepts in one cycle.

Test Plan:
- Reset: write 0x12345678 to r5, assert rst_n=0 asynchronously between edges -> readData1 (readReg1=5) = 0 immediately; writeCount = 0.
- Basic write and read: regWrite=1, writeReg=8, writeData=0xDEADBEEF, one edge. Then readReg1=8, readReg2=8 -> both ports = 0xDEADBEEF, dbgData (dbgReg=8) = 0xDEADBEEF, writeCount = 1.
- Register zero: regWrite=1, writeReg=0, writeData=0xFFFFFFFF, one edge -> readData1 (readReg1=0) = 0, writeCount unchanged.
- Bypass: BYPASS=1, r3 = 0x11. Drive regWrite=1, writeReg=3, writeData=0x22, readReg1=3 before the edge -> readData1 = 0x22 and dbgData = 0x11 pre-edge, dbgData = 0x22 post-edge. With BYPASS=0 -> readData1 = 0x11 pre-edge, 0x22 post-edge.
- Disabled write: regWrite=0, writeReg=9, writeData=0xAAAA, one edge -> r9 remains 0, writeCount unchanged.
- Full sweep with ALU hookup: write r1..r31 with value 0x100+i, then read pairs (ri, r(32-i)) into the ALU with ALUOperation=010 -> ALUResult = 0x200+32 for every i, writeCount = 31.
